mem_port_arbiter: RTL and testbench

- Responder for the pipeline's split instruction (port a) and data (port b) memory interfaces.
- Serves both ports from one physical memory port (pmem_*).
- Accepts level-held read/write requests, grants one port at a time with round-robin on contention, and forwards the latched request to pmem.
- Returns a one-cycle mem_resp pulse with registered read data.
- Sits between the datapath and the cache/physical memory.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: serves instruction port a and data port b from a
// single physical memory port, round-robin on contention, with an optional
// watchdog that forces completion if the physical side never responds.
module mem_port_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_a,
  input  logic             mem_write_a,
  input  logic [1:0]       mem_wmask_a,
  input  logic [WIDTH-1:0] mem_address_a,
  input  logic [WIDTH-1:0] mem_wdata_a,
  output logic             mem_resp_a,
  output logic [WIDTH-1:0] mem_rdata_a,
  input  logic             mem_read_b,
  input  logic             mem_write_b,
  input  logic [1:0]       mem_wmask_b,
  input  logic [WIDTH-1:0] mem_address_b,
  input  logic [WIDTH-1:0] mem_wdata_b,
  output logic             mem_resp_b,
  output logic [WIDTH-1:0] mem_rdata_b,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       pmem_wmask,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic             pmem_resp,
  input  logic [WIDTH-1:0] pmem_rdata,
  output logic             err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_A = 3'd1,
    SERVE_B = 3'd2,
    RESP_A  = 3'd3,
    RESP_B  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   last_b_q, last_b_d;   // 1 = port b was granted most recently
  logic   grant_a, grant_b;
  logic   req_a, req_b;
  logic   serving, timeout_hit, done;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [WIDTH-1:0] rdata_a_q, rdata_b_q;

  // Request captured at grant time; held stable for the whole transaction.
  logic             wr_p1;
  logic [WIDTH-1:0] addr_p1;
  logic [WIDTH-1:0] wdata_p1;
  logic [1:0]       wmask_p1;

  assign req_a       = mem_read_a | mem_write_a;
  assign req_b       = mem_read_b | mem_write_b;
  assign serving     = (state_q == SERVE_A) || (state_q == SERVE_B);
  assign timeout_hit = (TIMEOUT > 0) && serving && !pmem_resp && (cnt_q == TO_LAST);
  assign done        = serving && (pmem_resp || timeout_hit);

  // Next-state logic: round-robin grant in IDLE, completion in SERVE, single RESP cycle.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          grant_a = last_b_q;
          grant_b = !last_b_q;
        end else begin
          grant_a = req_a;
          grant_b = req_b;
        end
        if (grant_a) begin
          state_d  = SERVE_A;
          last_b_d = 1'b0;
        end else if (grant_b) begin
          state_d  = SERVE_B;
          last_b_d = 1'b1;
        end
      end
      SERVE_A: if (done) state_d = RESP_A;
      SERVE_B: if (done) state_d = RESP_B;
      RESP_A:  state_d = IDLE;
      RESP_B:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, watchdog, sticky error and per-port read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      if (grant_a || grant_b)
        cnt_q <= '0;
      else if (serving && !pmem_resp)
        cnt_q <= cnt_q + 1'b1;
      if (timeout_hit)
        err_q <= 1'b1;
      if (state_q == SERVE_A) begin
        if (pmem_resp && !wr_p1) rdata_a_q <= pmem_rdata;
        else if (timeout_hit)    rdata_a_q <= '0;
      end
      if (state_q == SERVE_B) begin
        if (pmem_resp && !wr_p1) rdata_b_q <= pmem_rdata;
        else if (timeout_hit)    rdata_b_q <= '0;
      end
    end
  end

  // Stage p1: latch the granted port's request; a write wins if read and write are both high.
  always_ff @(posedge clk) begin
    if (grant_a) begin
      wr_p1    <= mem_write_a;
      addr_p1  <= mem_address_a;
      wdata_p1 <= mem_wdata_a;
      wmask_p1 <= mem_wmask_a;
    end else if (grant_b) begin
      wr_p1    <= mem_write_b;
      addr_p1  <= mem_address_b;
      wdata_p1 <= mem_wdata_b;
      wmask_p1 <= mem_wmask_b;
    end
  end

  // Physical side is driven only while serving, so reset drops it immediately.
  assign pmem_read    = serving & ~wr_p1;
  assign pmem_write   = serving &  wr_p1;
  assign pmem_address = serving ? addr_p1  : '0;
  assign pmem_wdata   = serving ? wdata_p1 : '0;
  assign pmem_wmask   = serving ? wmask_p1 : 2'b00;

  assign mem_resp_a  = (state_q == RESP_A);
  assign mem_resp_b  = (state_q == RESP_B);
  assign mem_rdata_a = rdata_a_q;
  assign mem_rdata_b = rdata_b_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected physical
// requests and port responses; a pmem model and a response monitor pop them.
module tb_mem_port_arbiter;
  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read_a = 0, mem_write_a = 0, mem_read_b = 0, mem_write_b = 0;
  logic [1:0]   mem_wmask_a = 0, mem_wmask_b = 0;
  logic [W-1:0] mem_address_a = 0, mem_wdata_a = 0, mem_address_b = 0, mem_wdata_b = 0;
  logic         mem_resp_a, mem_resp_b;
  logic [W-1:0] mem_rdata_a, mem_rdata_b;
  logic         pmem_read, pmem_write;
  logic [1:0]   pmem_wmask;
  logic [W-1:0] pmem_address, pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [W-1:0] pmem_rdata = '0;
  logic         err;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_a(mem_read_a), .mem_write_a(mem_write_a), .mem_wmask_a(mem_wmask_a),
    .mem_address_a(mem_address_a), .mem_wdata_a(mem_wdata_a),
    .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b), .mem_wmask_b(mem_wmask_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
    .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           port_b;
    logic [W-1:0] rdata;
    int           cyc;
    bit           err;
  } resp_t;

  typedef struct {
    bit           wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [1:0]   wmask;
    int           cyc;
  } preq_t;

  resp_t rq[$];
  preq_t pq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // pmem model controls
  int           lat = 1;
  bit           hang = 0;
  bit           use_fixed = 0;
  logic [W-1:0] fixed_val = '0;
  int           pcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected at cycle %0d", nm, cyc);
  endtask

  // Physical memory model: checks each new request, responds after lat cycles.
  always @(negedge clk) begin : pmem_model
    preq_t p;
    if (pmem_read || pmem_write) begin
      if (pcnt == 0) begin
        if (pq.size() == 0) fail_evt("pmem_unexpected_req");
        else begin
          p = pq.pop_front();
          chk("pmem_start_cycle", 32'(cyc), 32'(p.cyc));
          chk("pmem_write", 32'(pmem_write), 32'(p.wr));
          chk("pmem_read", 32'(pmem_read), 32'(!p.wr));
          chk("pmem_address", 32'(pmem_address), 32'(p.addr));
          if (p.wr) begin
            chk("pmem_wdata", 32'(pmem_wdata), 32'(p.wdata));
            chk("pmem_wmask", 32'(pmem_wmask), 32'(p.wmask));
          end
        end
      end
      pcnt++;
      pmem_resp  = !hang && (pcnt == lat);
      pmem_rdata = use_fixed ? fixed_val : (pmem_address ^ 16'h5A5A);
    end else begin
      pcnt       = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = 16'hFFFF;
    end
  end

  // Response monitor: pops the scoreboard whenever a port completes.
  always @(negedge clk) begin : monitor
    resp_t r;
    if (rst_n) begin
      chk("resp_exclusive", 32'(mem_resp_a & mem_resp_b), 32'(0));
      chk("pmem_exclusive", 32'(pmem_read & pmem_write), 32'(0));
      if (mem_resp_a || mem_resp_b) begin
        if (rq.size() == 0) fail_evt("unexpected_resp");
        else begin
          r = rq.pop_front();
          chk("resp_port_b", 32'(mem_resp_b), 32'(r.port_b));
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("resp_rdata", 32'(r.port_b ? mem_rdata_b : mem_rdata_a), 32'(r.rdata));
          chk("resp_err", 32'(err), 32'(r.err));
        end
      end
    end
  end

  task automatic clear_reqs();
    mem_read_a = 0; mem_write_a = 0; mem_read_b = 0; mem_write_b = 0;
    mem_wmask_a = 0; mem_wmask_b = 0;
    mem_address_a = 0; mem_address_b = 0; mem_wdata_a = 0; mem_wdata_b = 0;
  endtask

  // One transaction on one port; request held until that port responds.
  task automatic do_txn(input bit pb, input bit wr, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input logic [1:0] wmask,
                        input int l, input bit hg, input logic [W-1:0] exp_rd,
                        input bit exp_err);
    resp_t r;
    preq_t p;
    int    t0;
    bit    seen;
    @(negedge clk);
    lat  = l;
    hang = hg;
    t0   = cyc;
    if (pb) begin
      mem_read_b = !wr; mem_write_b = wr; mem_address_b = addr;
      mem_wdata_b = wdata; mem_wmask_b = wmask;
    end else begin
      mem_read_a = !wr; mem_write_a = wr; mem_address_a = addr;
      mem_wdata_a = wdata; mem_wmask_a = wmask;
    end
    p = '{wr, addr, wdata, wmask, t0 + 1};
    pq.push_back(p);
    r = '{pb, exp_rd, hg ? (t0 + 1 + TO) : (t0 + 1 + l), exp_err};
    rq.push_back(r);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = pb ? mem_resp_b : mem_resp_a;
    end
    if (!seen) fail_evt("resp_wait_timeout");
    clear_reqs();
  endtask

  initial begin : stimulus
    int    t0;
    resp_t r;
    preq_t p;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pmem_read", 32'(pmem_read), 32'(0));
    chk("rst_pmem_write", 32'(pmem_write), 32'(0));
    chk("rst_pmem_address", 32'(pmem_address), 32'(0));
    chk("rst_pmem_wdata", 32'(pmem_wdata), 32'(0));
    chk("rst_pmem_wmask", 32'(pmem_wmask), 32'(0));
    chk("rst_resp_a", 32'(mem_resp_a), 32'(0));
    chk("rst_resp_b", 32'(mem_resp_b), 32'(0));
    chk("rst_rdata_a", 32'(mem_rdata_a), 32'(0));
    chk("rst_rdata_b", 32'(mem_rdata_b), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst_n = 1;

    // Single read on a, L=3
    use_fixed = 1; fixed_val = 16'h1234;
    do_txn(0, 0, 16'h0040, 16'h0000, 2'b00, 3, 0, 16'h1234, 0);

    // Write on b, L=1: read data of b stays at its reset value
    fixed_val = 16'hDEAD;
    do_txn(1, 1, 16'h0100, 16'hBEEF, 2'b01, 1, 0, 16'h0000, 0);
    chk("idle_rdata_a_hold", 32'(mem_rdata_a), 32'(16'h1234));
    use_fixed = 0;

    // Held read on a, L=2: IDLE after RESP samples it as a new transaction
    @(negedge clk);
    t0 = cyc; lat = 2; hang = 0;
    mem_read_a = 1; mem_address_a = 16'h0200;
    p = '{0, 16'h0200, 16'h0, 2'b00, t0 + 1}; pq.push_back(p);
    p = '{0, 16'h0200, 16'h0, 2'b00, t0 + 5}; pq.push_back(p);
    r = '{0, 16'h585A, t0 + 3, 0}; rq.push_back(r);
    r = '{0, 16'h585A, t0 + 7, 0}; rq.push_back(r);
    repeat (7) @(negedge clk);
    clear_reqs();

    // Watchdog: pmem never responds, then the next request is still served
    do_txn(0, 0, 16'h0300, 16'h0000, 2'b00, 1, 1, 16'h0000, 1);
    do_txn(1, 0, 16'h0400, 16'h0000, 2'b00, 1, 0, 16'h5E5A, 1);

    // Reset in the middle of SERVE
    @(negedge clk);
    t0 = cyc; hang = 1;
    mem_read_a = 1; mem_address_a = 16'h0500;
    p = '{0, 16'h0500, 16'h0, 2'b00, t0 + 1}; pq.push_back(p);
    repeat (2) @(negedge clk);
    chk("mid_pmem_read_before_rst", 32'(pmem_read), 32'(1));
    rst_n = 0;
    #1;
    chk("mid_rst_pmem_read", 32'(pmem_read), 32'(0));
    chk("mid_rst_pmem_address", 32'(pmem_address), 32'(0));
    chk("mid_rst_resp_a", 32'(mem_resp_a), 32'(0));
    chk("mid_rst_err", 32'(err), 32'(0));
    clear_reqs();
    hang = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_rdata_b", 32'(mem_rdata_b), 32'(0));

    // Contention straight out of reset: b, a, b, a with L=1
    rst_n = 1;
    t0 = cyc; lat = 1;
    mem_read_a = 1; mem_address_a = 16'h0A00;
    mem_read_b = 1; mem_address_b = 16'h0B00;
    for (int k = 0; k < 4; k++) begin
      p = '{0, (k % 2 == 0) ? 16'h0B00 : 16'h0A00, 16'h0, 2'b00, t0 + 1 + 3 * k};
      pq.push_back(p);
      r = '{(k % 2 == 0), (k % 2 == 0) ? 16'h515A : 16'h505A, t0 + 2 + 3 * k, 0};
      rq.push_back(r);
    end
    repeat (11) @(negedge clk);
    clear_reqs();

    repeat (6) @(negedge clk);
    chk("scoreboard_resp_drained", 32'(rq.size()), 32'(0));
    chk("scoreboard_pmem_drained", 32'(pq.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : global_bound
    #200000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "bench time limit expired");
  end

endmodule
